// File: rtl/jogo_playseq_uc.sv
// Control unit for the sequence-replay memory game: shows the sequence
// prefix, checks each player move, grows the round, ends in win/loss/timeout.
module jogo_playseq_uc #(
    parameter int DISPLAY_CYCLES = 500,
    parameter int GAP_CYCLES     = 250,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       tem_jogada,
    input  logic       chavesIgualMemoria,
    input  logic       enderecoIgualSequencia,
    input  logic       fimS,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraS,
    output logic       contaS,
    output logic       zeraR,
    output logic       registraR,
    output logic       leds_en,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam int MAX_A = (DISPLAY_CYCLES > GAP_CYCLES) ? DISPLAY_CYCLES : GAP_CYCLES;
    localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int TW    = $clog2(MAX_C) + 1;

    localparam logic [TW-1:0] DISP_LAST = TW'(DISPLAY_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        INICIAL           = 4'h0,
        PREPARACAO        = 4'h1,
        MOSTRA            = 4'h2,
        INTERVALO         = 4'h3,
        FIM_MOSTRA        = 4'h4,
        ESPERA_JOGADA     = 4'h5,
        REGISTRA          = 4'h6,
        COMPARACAO        = 4'h7,
        PROXIMA_JOGADA    = 4'h8,
        PROXIMA_SEQUENCIA = 4'h9,
        FIM_ACERTOU       = 4'hA,
        FIM_TIMEOUT       = 4'hD,
        FIM_ERROU         = 4'hE
    } state_t;

    state_t        state;
    state_t        next;
    logic [TW-1:0] tmr;
    logic          counting;

    assign counting = (state == MOSTRA) || (state == INTERVALO)
                   || (state == ESPERA_JOGADA);

    // The timer restarts on every state change so each phase counts from zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= INICIAL;
            tmr   <= '0;
        end else begin
            state <= next;
            if ((next != state) || !counting)
                tmr <= '0;
            else
                tmr <= tmr + TW'(1);
        end
    end

    always_comb begin
        next      = state;
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraS     = 1'b0;
        contaS    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        leds_en   = 1'b0;
        pronto    = 1'b0;
        ganhou    = 1'b0;
        perdeu    = 1'b0;
        timeout   = 1'b0;
        case (state)
            INICIAL: begin
                if (jogar)
                    next = PREPARACAO;
            end
            PREPARACAO: begin
                zeraE = 1'b1;
                zeraS = 1'b1;
                zeraR = 1'b1;
                next  = MOSTRA;
            end
            MOSTRA: begin
                leds_en = 1'b1;
                if (tmr == DISP_LAST)
                    next = enderecoIgualSequencia ? FIM_MOSTRA : INTERVALO;
            end
            INTERVALO: begin
                if (tmr == GAP_LAST) begin
                    contaE = 1'b1;
                    next   = MOSTRA;
                end
            end
            FIM_MOSTRA: begin
                zeraE = 1'b1;
                zeraR = 1'b1;
                next  = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
                // A press on the terminal-count cycle still counts as a move.
                if (tem_jogada)
                    next = REGISTRA;
                else if (tmr == TMO_LAST)
                    next = FIM_TIMEOUT;
            end
            REGISTRA: begin
                registraR = 1'b1;
                next      = COMPARACAO;
            end
            COMPARACAO: begin
                if (!chavesIgualMemoria)
                    next = FIM_ERROU;
                else if (enderecoIgualSequencia && fimS)
                    next = FIM_ACERTOU;
                else if (enderecoIgualSequencia)
                    next = PROXIMA_SEQUENCIA;
                else
                    next = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA: begin
                contaE = 1'b1;
                next   = ESPERA_JOGADA;
            end
            PROXIMA_SEQUENCIA: begin
                contaS = 1'b1;
                zeraE  = 1'b1;
                next   = MOSTRA;
            end
            FIM_ACERTOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
                if (jogar)
                    next = PREPARACAO;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
                if (jogar)
                    next = PREPARACAO;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                perdeu = 1'b1;
                if (jogar)
                    next = PREPARACAO;
            end
            default: next = INICIAL;
        endcase
    end

    assign db_estado = state;

endmodule
